mux3_bus_arbiter: RTL
=====================

// Module: mux3_bus_arbiter
// PURPOSE
//  Round-robin arbiter and sequencer for the shared 16-bit 3-input operand/bus mux.
//  Three requesters (A, B, C) each present a word and a request line.
//  Grants one requester at a time, drives the mux select, and captures the selected word
//  into a 1-entry output register with a valid/ready handshake.
//  Sits between register-file/ALU sources and the accumulator write path.
// PARAMETERS
//  DATA_W     16   width of each data input and of out_data
//  BURST_MAX  4    max words accepted per grant (1..15)
//  CNT_W      4    beat-counter width; must hold BURST_MAX-1
// PORTS
//  clk        in   1       system clock, rising edge
//  rst_n      in   1       asynchronous, active-low reset
//  req        in   3       request per source; bit0=A, bit1=B, bit2=C
//  a_data     in   DATA_W  source A word
//  b_data     in   DATA_W  source B word
//  c_data     in   DATA_W  source C word
//  gnt        out  3       one-hot grant, registered
//  ack        out  3       one-hot pulse: granted source's word captured this cycle
//  sel        out  2       mux select; 0=A, 1=B, 2=C; 3 is never driven
//  out_data   out  DATA_W  captured word
//  out_valid  out  1       out_data holds an unconsumed word
//  out_ready  in   1       downstream accepts; transfer when out_valid && out_ready
//  busy       out  1       FSM not in IDLE
// BEHAVIOUR
//  Reset (async, rst_n=0): gnt=0, ack=0, sel=0, out_data=0, out_valid=0, busy=0,
//   state=IDLE, beat=0, last=2 (first priority order A,B,C). Mid-burst reset drops the word.
//  States: IDLE, GRANT.
//  IDLE: if req!=0, pick the first set bit scanning from last+1 (mod 3).
//   Next cycle: gnt=onehot(pick), sel=pick, beat=0, state=GRANT. If req==0, stay in IDLE.
//  GRANT, granted source i:
//   - space = !out_valid || out_ready.
//   - accept = req[i] && space. On accept: out_data<=mux(sel), out_valid<=1,
//     ack[i]=1 combinational this cycle, beat<=beat+1.
//   - End of grant: (!req[i]) or (accept && beat==BURST_MAX-1).
//   - On end: gnt<=0, sel<=0, last<=i, state<=IDLE. IDLE always costs 1 arbitration cycle.
//  Output register:
//   - out_valid clears on out_ready when no new accept occurs in the same cycle.
//   - Simultaneous drain and capture keeps out_valid=1 and loads the new word.
//   - Downstream stall (out_ready=0, out_valid=1) holds grant and beat; ack stays 0.
//  Latency: req rises in cycle 0 -> gnt/sel in cycle 1 -> ack in cycle 1 if space
//   -> out_valid in cycle 2. Throughput: 1 word/cycle while granted and not stalled.
//  Fairness:
//   - A source deasserting req mid-burst ends its grant. Data in that cycle is not taken.
//   - A source holding req through BURST_MAX beats is rotated out.
//   - It can regain the grant only after the other pending sources are served.
//  Invariants: gnt one-hot or zero; ack is a subset of gnt; sel==index(gnt) when gnt!=0, else 0.
//  busy==(state==GRANT).
// STRUCTURE
//  Package mux3_arb_pkg: state encodings ST_IDLE/ST_GRANT; SEL_A=2'd0, SEL_B=2'd1, SEL_C=2'd2.
//  Sub-module rr_pick3 (combinational): inputs req[2:0], last[1:0]; outputs pick[1:0], any.
//  The data mux is instantiated inside this block, driven by sel.
// TESTING
//  1. Reset: rst_n=0 mid-burst -> all outputs 0 immediately; after release, req=3'b111
//     -> grants A first.
//  2. Single source: req=3'b010, b_data=16'h1234, out_ready=1 -> gnt=3'b010 and sel=1
//     in cycle 1; out_data=16'h1234 with out_valid=1 in cycle 2; 4 acks, then IDLE.
//  3. Round-robin: req=3'b111 held, BURST_MAX=4 -> grant order A,B,C,A.
//     Each grant gives exactly 4 acks, separated by 1 IDLE cycle.
//  4. Backpressure: out_ready=0 after the first capture -> ack=0, out_data held, grant held.
//     out_ready=1 -> one transfer per cycle resumes; no word lost or duplicated.
//  5. Early drop: C granted, req[2] falls after 2 acks -> grant ends, last=2.
//     Pending A (req=3'b001) is granted next.
//  6. Drain+capture same cycle: out_valid=1, out_ready=1, accept=1
//     -> out_valid stays 1 and out_data updates to the new word.

Source files
------------

// File: rtl/mux3_arb_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// mux3_arb_pkg: shared types and helpers for the 3-source bus arbiter
// Rev 1.0
// ------------------------------------------------------------------
package mux3_arb_pkg;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  localparam logic [1:0] SEL_A = 2'd0;
  localparam logic [1:0] SEL_B = 2'd1;
  localparam logic [1:0] SEL_C = 2'd2;

  // Next source in the fixed A -> B -> C -> A rotation
  function automatic logic [1:0] rr_next(input logic [1:0] idx);
    return (idx >= SEL_C) ? SEL_A : idx + 2'd1;
  endfunction

  function automatic logic [2:0] onehot3(input logic [1:0] idx);
    logic [2:0] v;
    v = 3'b000;
    case (idx)
      SEL_A:   v = 3'b001;
      SEL_B:   v = 3'b010;
      SEL_C:   v = 3'b100;
      default: v = 3'b000;
    endcase
    return v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_pick3.sv
`default_nettype none
// ------------------------------------------------------------------
// rr_pick3: picks the first requester after 'last' in round-robin order
// Rev 1.0
// ------------------------------------------------------------------
module rr_pick3
  import mux3_arb_pkg::*;
(
  input  logic [2:0] req,
  input  logic [1:0] last,
  output logic [1:0] pick,
  output logic       any
);

  logic [1:0] cand1;
  logic [1:0] cand2;
  logic [1:0] cand3;

  assign cand1 = rr_next(last);
  assign cand2 = rr_next(cand1);
  assign cand3 = rr_next(cand2);
  assign any   = |req;

  always_comb begin
    pick = SEL_A;
    if (req[cand1])
      pick = cand1;
    else if (req[cand2])
      pick = cand2;
    else if (req[cand3])
      pick = cand3;
  end

endmodule
`default_nettype wire

// File: rtl/mux3_bus_arbiter.sv
`default_nettype none
// ------------------------------------------------------------------
// mux3_bus_arbiter: round-robin sequencer for the 3-input bus mux with
// a 1-entry valid/ready output register. Rev 1.0
// ------------------------------------------------------------------
module mux3_bus_arbiter
  import mux3_arb_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int BURST_MAX = 4,
  parameter int CNT_W     = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [2:0]        req,
  input  logic [DATA_W-1:0] a_data,
  input  logic [DATA_W-1:0] b_data,
  input  logic [DATA_W-1:0] c_data,
  output logic [2:0]        gnt,
  output logic [2:0]        ack,
  output logic [1:0]        sel,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy
);

  state_t             state;
  state_t             state_nxt;
  logic [1:0]         last;
  logic [CNT_W-1:0]   beat;
  logic [1:0]         pick;
  logic               any;
  logic [DATA_W-1:0]  mux_data;
  logic               space;
  logic               cur_req;
  logic               accept;
  logic               last_beat;
  logic               grant_end;

  rr_pick3 u_pick (
    .req  (req),
    .last (last),
    .pick (pick),
    .any  (any)
  );

  always_comb begin
    mux_data = a_data;
    case (sel)
      SEL_B:   mux_data = b_data;
      SEL_C:   mux_data = c_data;
      default: mux_data = a_data;
    endcase
  end

  // gnt is one-hot on the granted source, so masking req by it gives req[sel]
  assign cur_req   = |(req & gnt);
  assign space     = !out_valid || out_ready;
  assign accept    = (state == ST_GRANT) && cur_req && space;
  assign last_beat = (beat == CNT_W'(BURST_MAX - 1));
  assign grant_end = (state == ST_GRANT) && (!cur_req || (accept && last_beat));
  assign ack       = gnt & {3{accept}};
  assign busy      = (state == ST_GRANT);

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (any)       state_nxt = ST_GRANT;
      ST_GRANT: if (grant_end) state_nxt = ST_IDLE;
      default:                 state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= ST_IDLE;
    else
      state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt  <= 3'b000;
      sel  <= SEL_A;
      beat <= '0;
      last <= SEL_C;
    end else if (state == ST_IDLE) begin
      if (any) begin
        gnt  <= onehot3(pick);
        sel  <= pick;
        beat <= '0;
      end
    end else begin
      if (accept)
        beat <= beat + 1'b1;
      if (grant_end) begin
        gnt  <= 3'b000;
        sel  <= SEL_A;
        last <= sel;
      end
    end
  end

  // A capture in the same cycle as a drain keeps the register full
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data  <= '0;
      out_valid <= 1'b0;
    end else if (accept) begin
      out_data  <= mux_data;
      out_valid <= 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
`default_nettype wire
